// File: rtl/column_scan_coord_encoder_if.sv
// Scan/coordinate bundle between game logic and the LED column scanner.
// Game logic owns enable/hold/hold_col; the scanner owns the display drive outputs.
interface column_scan_coord_encoder_if #(
  parameter int NUM_COLS = 5,
  parameter int IDX_W    = 4
);
  logic                enable;
  logic                hold;
  logic [IDX_W-1:0]    hold_col;
  logic [IDX_W-1:0]    col_idx;
  logic [NUM_COLS-1:0] col_sel;
  logic [3:0]          coord_code;
  logic                coord_valid;
  logic                frame_tick;

  modport master (
    output enable, hold, hold_col,
    input  col_idx, col_sel, coord_code, coord_valid, frame_tick
  );

  modport slave (
    input  enable, hold, hold_col,
    output col_idx, col_sel, coord_code, coord_valid, frame_tick
  );
endinterface

// File: rtl/column_scan_coord_encoder.sv
// Time-multiplexed LED column scanner with a blank cycle between columns, hold-to-column
// support and a BCD coordinate digit for the 7-segment path.
module column_scan_coord_encoder #(
  parameter int NUM_COLS       = 5,
  parameter int IDX_W          = 4,
  parameter int DWELL          = 1000,
  parameter int CODE_OFFSET    = 1,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  column_scan_coord_encoder_if.slave  bus
);

  localparam int                  CNT_W      = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0]    COL_LAST   = IDX_W'(NUM_COLS - 1);
  localparam logic [IDX_W-1:0]    COL_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W:0]      COL_LIMIT  = (IDX_W + 1)'(NUM_COLS);
  localparam logic [NUM_COLS-1:0] SEL_IDLE   = (COL_ACTIVE_LOW != 0) ? {NUM_COLS{1'b1}}
                                                                     : {NUM_COLS{1'b0}};

  // IDLE: waiting for the first enabled edge after reset; PAUSE: frozen by enable=0.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
  logic [3:0]          coord_code_q, coord_code_d;
  logic                coord_valid_q, coord_valid_d;
  logic                frame_tick_q, frame_tick_d;
  logic [IDX_W-1:0]    next_col_s;
  logic                natural_wrap_s;
  logic                advance_s;

  // Displayed digit: columns whose offset value exceeds 9 show a blank digit.
  function automatic logic [3:0] coord_of(input logic [IDX_W-1:0] idx);
    logic [4:0] v;
    v = 5'(idx) + 5'(CODE_OFFSET);
    return (v <= 5'd9) ? v[3:0] : 4'hF;
  endfunction

  function automatic logic [NUM_COLS-1:0] drive_of(input logic [IDX_W-1:0] idx);
    logic [NUM_COLS-1:0] s;
    for (int i = 0; i < NUM_COLS; i++) begin
      s[i] = (idx == IDX_W'(i));
    end
    return (COL_ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  // Column chosen for the following slot; out-of-range hold requests keep the current column.
  always_comb begin
    next_col_s     = col_idx_q;
    natural_wrap_s = 1'b0;
    if (bus.hold) begin
      if ({1'b0, bus.hold_col} < COL_LIMIT) begin
        next_col_s = bus.hold_col;
      end else begin
        next_col_s = col_idx_q;
      end
    end else if (col_idx_q == COL_LAST) begin
      next_col_s     = COL_ZERO;
      natural_wrap_s = 1'b1;
    end else begin
      next_col_s = col_idx_q + IDX_W'(1);
    end
  end

  // Slot sequencing and next output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    col_idx_d     = col_idx_q;
    col_sel_d     = SEL_IDLE;
    coord_code_d  = coord_code_q;
    coord_valid_d = 1'b0;
    frame_tick_d  = 1'b0;
    advance_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d      = ST_RUN;
          cnt_d        = CNT_ZERO;
          col_idx_d    = COL_ZERO;
          coord_code_d = coord_of(COL_ZERO);
          frame_tick_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.enable) begin
          advance_s = 1'b1;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (bus.enable) begin
          state_d = ST_RUN;
          // A slot frozen on its blank cycle shows that blank cycle again.
          advance_s = (cnt_q != CNT_ZERO);
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance_s) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = CNT_ZERO;
        col_idx_d    = next_col_s;
        coord_code_d = coord_of(next_col_s);
        frame_tick_d = natural_wrap_s;
      end else begin
        cnt_d         = cnt_q + CNT_W'(1);
        col_sel_d     = drive_of(col_idx_q);
        coord_valid_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and output registers; reset wins over enable and hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      col_idx_q     <= COL_ZERO;
      col_sel_q     <= SEL_IDLE;
      coord_code_q  <= 4'hF;
      coord_valid_q <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_idx_q     <= col_idx_d;
      col_sel_q     <= col_sel_d;
      coord_code_q  <= coord_code_d;
      coord_valid_q <= coord_valid_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bus.col_idx     = col_idx_q;
  assign bus.col_sel     = col_sel_q;
  assign bus.coord_code  = coord_code_q;
  assign bus.coord_valid = coord_valid_q;
  assign bus.frame_tick  = frame_tick_q;

endmodule
